onehot_sum_ctrl: RTL and testbench

Sequencing controller for the one-hot position-sum datapath. It buffers up to eight 16-bit words from a valid/ready write port and, on `start`, feeds one word per cycle through a position encoder. It accumulates the position sum modulo 256 and drives the board LEDs with either the sum or its parity, selected by `PB`. It sits between the switch/loader front end and the LED output of the board top level.

---
 rtl/onehot_pkg.sv | 15 +
 rtl/onehot_pos.sv | 22 ++
 rtl/onehot_sum_ctrl.sv | 137 +++++++++++++
 tb/tb_onehot_sum_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/onehot_pkg.sv
// Shared types and defaults for the one-hot position-sum controller.
package onehot_pkg;
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_WORD_W = 16;
    localparam int DEF_SUM_W  = 8;
    localparam int ENC_W      = 5;
    localparam logic [7:0] LED_RESET = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE,
        SHOW
    } state_e;
endpackage

// File: rtl/onehot_pos.sv
// Combinational position encoder: popcount and (highest set bit index + 1).
module onehot_pos
    import onehot_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic [WORD_W-1:0] word,
    output logic [ENC_W-1:0]  ones,
    output logic [ENC_W-1:0]  pos
);
    // pos is only meaningful when ones == 1; otherwise it tracks the top set bit
    always_comb begin
        ones = '0;
        pos  = '0;
        for (int i = 0; i < WORD_W; i++) begin
            if (word[i]) begin
                ones = ones + ENC_W'(1);
                pos  = ENC_W'(i + 1);
            end
        end
    end
endmodule

// File: rtl/onehot_sum_ctrl.sv
// Buffers words, then walks them through the position encoder accumulating
// a mod-2^SUM_W position sum and driving the LEDs with the sum or its parity.
module onehot_sum_ctrl
    import onehot_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int WORD_W = DEF_WORD_W,
    parameter int SUM_W  = DEF_SUM_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_valid,
    input  logic [WORD_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              start,
    input  logic              PB,
    output logic              busy,
    output logic              done,
    output logic [SUM_W-1:0]  sum,
    output logic [3:0]        err_count,
    output logic [SUM_W-1:0]  output_led
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    state_e                         state_q, state_d;
    logic [CNT_W-1:0]               count_q, count_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [SUM_W-1:0]               sum_q, sum_d;
    logic [3:0]                     err_q, err_d;
    logic [SUM_W-1:0]               led_q, led_d;
    logic [DEPTH-1:0][WORD_W-1:0]   mem_q;
    logic                           mem_we;
    logic [ENC_W-1:0]               ones, pos;
    logic                           last;
    logic [SUM_W-1:0]               led_view;

    onehot_pos #(.WORD_W(WORD_W)) u_pos (
        .word (mem_q[idx_q]),
        .ones (ones),
        .pos  (pos)
    );

    assign last     = (CNT_W'(idx_q) == count_q - CNT_W'(1));
    assign led_view = PB ? sum_q : {{(SUM_W-1){1'b0}}, ^sum_q};

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        idx_d    = idx_q;
        sum_d    = sum_q;
        err_d    = err_q;
        led_d    = led_q;
        mem_we   = 1'b0;
        wr_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                wr_ready = (count_q < CNT_W'(DEPTH)) && !start;
                if (start && count_q != '0) begin
                    idx_d   = '0;
                    sum_d   = '0;
                    err_d   = '0;
                    state_d = RUN;
                end else if (wr_valid && wr_ready) begin
                    mem_we  = 1'b1;
                    count_d = count_q + CNT_W'(1);
                end
            end
            RUN: begin
                busy = 1'b1;
                if (ones == ENC_W'(1)) begin
                    sum_d = sum_q + SUM_W'(pos);
                end else begin
                    sum_d = sum_q - SUM_W'(1);
                    if (err_q != 4'd15) err_d = err_q + 4'd1;
                end
                idx_d = idx_q + IDX_W'(1);
                if (last) state_d = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                led_d   = led_view;
                state_d = SHOW;
            end
            SHOW: begin
                led_d = led_view;
                if (start) begin
                    idx_d   = '0;
                    sum_d   = '0;
                    err_d   = '0;
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
        // Clear overrides whatever the state logic decided this cycle
        if (clr) begin
            state_d = IDLE;
            count_d = '0;
            idx_d   = '0;
            sum_d   = '0;
            err_d   = '0;
            led_d   = SUM_W'(LED_RESET);
            mem_we  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            idx_q   <= '0;
            sum_q   <= '0;
            err_q   <= '0;
            led_q   <= SUM_W'(LED_RESET);
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            err_q   <= err_d;
            led_q   <= led_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[count_q[IDX_W-1:0]] <= wr_data;
    end

    assign sum        = sum_q;
    assign err_count  = err_q;
    assign output_led = led_q;
endmodule

// File: tb/tb_onehot_sum_ctrl.sv
// Directed bench for onehot_sum_ctrl with hand-computed expectations.
module tb_onehot_sum_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        wr_valid = 1'b0;
    logic [15:0] wr_data = '0;
    logic        wr_ready;
    logic        start = 1'b0;
    logic        PB = 1'b1;
    logic        busy;
    logic        done;
    logic [7:0]  sum;
    logic [3:0]  err_count;
    logic [7:0]  output_led;

    int checks = 0;
    int errors = 0;

    onehot_sum_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .start      (start),
        .PB         (PB),
        .busy       (busy),
        .done       (done),
        .sum        (sum),
        .err_count  (err_count),
        .output_led (output_led)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [15:0] w);
        wr_valid = 1'b1;
        wr_data  = w;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    // Pulses start, then observes a bounded window of cycles; measures only.
    task automatic run_watch(output int busy_cnt, output int done_cnt, output int done_at,
                             output logic [7:0] s_at, output logic [3:0] e_at);
        busy_cnt = 0; done_cnt = 0; done_at = -1; s_at = 'x; e_at = 'x;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = i;
                s_at = sum;
                e_at = err_count;
            end
            step();
        end
    endtask

    task automatic test_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b expected 1", wr_ready); end
        checks++; if (output_led !== 8'hFF) begin errors++; $display("FAIL reset_led: got %h expected ff", output_led); end
        checks++; if (sum !== 8'h00) begin errors++; $display("FAIL reset_sum: got %h expected 00", sum); end
        checks++; if (err_count !== 4'd0) begin errors++; $display("FAIL reset_err: got %0d expected 0", err_count); end
    endtask

    task automatic test_main_run();
        logic [15:0] words [8] = '{16'h0000, 16'h8800, 16'h0100, 16'h8000,
                                   16'h0001, 16'h0800, 16'h8110, 16'h0080};
        int bc, dc, da; logic [7:0] s; logic [3:0] e;
        foreach (words[i]) write_word(words[i]);
        PB = 1'b1;
        run_watch(bc, dc, da, s, e);
        checks++; if (bc !== 9) begin errors++; $display("FAIL main_busy_cycles: got %0d expected 9", bc); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL main_done_pulses: got %0d expected 1", dc); end
        checks++; if (da !== 8) begin errors++; $display("FAIL main_done_at: got %0d expected 8", da); end
        checks++; if (s !== 8'h2B) begin errors++; $display("FAIL main_sum: got %h expected 2b", s); end
        checks++; if (e !== 4'd3) begin errors++; $display("FAIL main_err: got %0d expected 3", e); end
        checks++; if (output_led !== 8'h2B) begin errors++; $display("FAIL main_led_sum: got %h expected 2b", output_led); end
        PB = 1'b0;
        step();
        checks++; if (output_led !== 8'h00) begin errors++; $display("FAIL main_led_parity: got %h expected 00", output_led); end
        PB = 1'b1;
        step();
        checks++; if (output_led !== 8'h2B) begin errors++; $display("FAIL main_led_back: got %h expected 2b", output_led); end
    endtask

    task automatic test_rerun_and_clr();
        int bc, dc, da; logic [7:0] s; logic [3:0] e;
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL show_wr_ready: got %b expected 0", wr_ready); end
        run_watch(bc, dc, da, s, e);
        checks++; if (da !== 8) begin errors++; $display("FAIL rerun_done_at: got %0d expected 8", da); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL rerun_done_pulses: got %0d expected 1", dc); end
        checks++; if (s !== 8'h2B) begin errors++; $display("FAIL rerun_sum: got %h expected 2b", s); end
        checks++; if (e !== 4'd3) begin errors++; $display("FAIL rerun_err: got %0d expected 3", e); end
        do_clr();
        checks++; if (output_led !== 8'hFF) begin errors++; $display("FAIL clr_led: got %h expected ff", output_led); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL clr_wr_ready: got %b expected 1", wr_ready); end
        checks++; if (sum !== 8'h00) begin errors++; $display("FAIL clr_sum: got %h expected 00", sum); end
        checks++; if (err_count !== 4'd0) begin errors++; $display("FAIL clr_err: got %0d expected 0", err_count); end
    endtask

    task automatic test_single_zero();
        int bc, dc, da; logic [7:0] s; logic [3:0] e;
        write_word(16'h0000);
        run_watch(bc, dc, da, s, e);
        checks++; if (da !== 1) begin errors++; $display("FAIL zero_done_at: got %0d expected 1", da); end
        checks++; if (s !== 8'hFF) begin errors++; $display("FAIL zero_sum: got %h expected ff", s); end
        checks++; if (e !== 4'd1) begin errors++; $display("FAIL zero_err: got %0d expected 1", e); end
        checks++; if (output_led !== 8'hFF) begin errors++; $display("FAIL zero_led: got %h expected ff", output_led); end
        do_clr();
    endtask

    task automatic test_full_and_empty();
        int bc, dc, da; logic [7:0] s; logic [3:0] e;
        for (int i = 0; i < 8; i++) write_word(16'h0001);
        wr_valid = 1'b1;
        wr_data  = 16'h8000;
        #1;
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_wr_ready: got %b expected 0", wr_ready); end
        step();
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_wr_ready_held: got %b expected 0", wr_ready); end
        wr_valid = 1'b0;
        run_watch(bc, dc, da, s, e);
        checks++; if (da !== 8) begin errors++; $display("FAIL full_done_at: got %0d expected 8", da); end
        checks++; if (s !== 8'h08) begin errors++; $display("FAIL full_sum: got %h expected 08", s); end
        checks++; if (e !== 4'd0) begin errors++; $display("FAIL full_err: got %0d expected 0", e); end
        do_clr();
        run_watch(bc, dc, da, s, e);
        checks++; if (bc !== 0) begin errors++; $display("FAIL empty_busy_cycles: got %0d expected 0", bc); end
        checks++; if (dc !== 0) begin errors++; $display("FAIL empty_done_pulses: got %0d expected 0", dc); end
    endtask

    task automatic test_async_reset();
        int dc;
        write_word(16'h0001);
        write_word(16'h0002);
        write_word(16'h0004);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        checks++; if (sum !== 8'h03) begin errors++; $display("FAIL arst_pre_sum: got %h expected 03", sum); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (output_led !== 8'hFF) begin errors++; $display("FAIL arst_led: got %h expected ff", output_led); end
        checks++; if (sum !== 8'h00) begin errors++; $display("FAIL arst_sum: got %h expected 00", sum); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b expected 0", busy); end
        checks++; if (err_count !== 4'd0) begin errors++; $display("FAIL arst_err: got %0d expected 0", err_count); end
        step();
        #3;
        rst = 1'b0;
        dc = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done) dc++;
        end
        checks++; if (dc !== 0) begin errors++; $display("FAIL arst_no_done: got %0d expected 0", dc); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL arst_wr_ready: got %b expected 1", wr_ready); end
    endtask

    task automatic test_start_with_write();
        int bc, dc, da; logic [7:0] s; logic [3:0] e;
        write_word(16'h0004);
        write_word(16'h0010);
        start    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 16'h0002;
        #1;
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL sw_wr_ready: got %b expected 0", wr_ready); end
        step();
        start    = 1'b0;
        wr_valid = 1'b0;
        bc = 0; dc = 0; da = -1; s = 'x; e = 'x;
        for (int i = 0; i < 12; i++) begin
            if (busy) bc++;
            if (done) begin dc++; da = i; s = sum; e = err_count; end
            step();
        end
        checks++; if (da !== 2) begin errors++; $display("FAIL sw_done_at: got %0d expected 2", da); end
        checks++; if (bc !== 3) begin errors++; $display("FAIL sw_busy_cycles: got %0d expected 3", bc); end
        checks++; if (s !== 8'h08) begin errors++; $display("FAIL sw_sum: got %h expected 08", s); end
        checks++; if (e !== 4'd0) begin errors++; $display("FAIL sw_err: got %0d expected 0", e); end
    endtask

    initial begin
        step();
        step();
        #2;
        rst = 1'b0;
        step();
        test_reset();
        test_main_run();
        test_rerun_and_clr();
        test_single_zero();
        test_full_and_empty();
        test_async_reset();
        test_start_with_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
